// File: rtl/pll_clken_gen.sv
// pll_clken_gen: lock-filtered PLL supervisor with NCH phase-aligned clock-enable / divided-clock channels
//   CLKI    rising-edge clock (PLL CLKOP)      RST    sync active-high reset
//   LOCK    async PLL lock                     SYNC   restart all channel counters (RUN only)
//   CFG_WE/CFG_CH/CFG_DIV/CFG_PH  shadow config write (DIV 0 -> 1, PH clamped to DIV-1)
//   EN      per-channel output enable          CE     one-cycle strobe per period
//   CLKO    divided square wave                READY  lock filtered good   RSTO  registered !READY
module pll_clken_gen #(
  parameter int NCH = 3,
  parameter int CW = 16,
  parameter int LOCK_FILT = 256,
  parameter int DEF_DIV = 2
) (
  input  logic           CLKI,
  input  logic           RST,
  input  logic           LOCK,
  input  logic           SYNC,
  input  logic           CFG_WE,
  input  logic [2:0]     CFG_CH,
  input  logic [CW-1:0]  CFG_DIV,
  input  logic [CW-1:0]  CFG_PH,
  input  logic [NCH-1:0] EN,
  output logic [NCH-1:0] CE,
  output logic [NCH-1:0] CLKO,
  output logic           READY,
  output logic           RSTO
);
  localparam int FW = $clog2(LOCK_FILT + 1);
  typedef enum logic [1:0] {IDLE, FILT, RUN} state_t;
  state_t state, state_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic lock_m, lock_s, run, resync;
  logic [CW-1:0] wdiv, wph;
  always_ff @(posedge CLKI) begin
    if (RST) begin
      {lock_m, lock_s} <= 2'b00;
      state <= IDLE;
      fcnt <= '0;
      RSTO <= 1'b1;
    end else begin
      {lock_m, lock_s} <= {LOCK, lock_m};
      state <= state_nx;
      fcnt <= fcnt_nx;
      RSTO <= ~run;
    end
  end
  // The filter counter only advances in FILT; every other path clears it.
  always_comb begin
    state_nx = state;
    fcnt_nx = '0;
    if (!lock_s) state_nx = IDLE;
    else if (state == IDLE) state_nx = FILT;
    else if (state == FILT) begin
      if (fcnt == FW'(LOCK_FILT - 1)) state_nx = RUN;
      else fcnt_nx = fcnt + FW'(1);
    end
  end
  assign run = state == RUN;
  assign READY = run;
  // Entering RUN restarts every channel exactly like an explicit SYNC.
  assign resync = (run && SYNC) || (!run && state_nx == RUN);
  assign wdiv = CFG_DIV == '0 ? CW'(1) : CFG_DIV;
  assign wph = CFG_PH >= wdiv ? wdiv - CW'(1) : CFG_PH;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] adiv, aph, sdiv, sph, cnt, nsdiv, nsph, half;
    logic hit, wrap, ce, ck;
    // A write landing on the wrap/resync cycle goes straight through to the active set.
    always_comb begin
      hit = CFG_WE && CFG_CH == 3'(i);
      nsdiv = hit ? wdiv : sdiv;
      nsph = hit ? wph : sph;
      wrap = run && cnt == adiv - CW'(1);
      half = (adiv >> 1) + CW'(adiv[0]);
    end
    always_ff @(posedge CLKI) begin
      if (RST) begin
        adiv <= CW'(DEF_DIV);
        sdiv <= CW'(DEF_DIV);
        aph <= '0;
        sph <= '0;
        cnt <= '0;
        ce <= 1'b0;
        ck <= 1'b0;
      end else begin
        sdiv <= nsdiv;
        sph <= nsph;
        if (wrap || resync) begin
          adiv <= nsdiv;
          aph <= nsph;
        end
        cnt <= (!run || wrap || resync) ? '0 : cnt + CW'(1);
        ce <= run && EN[i] && cnt == aph;
        ck <= run && EN[i] && cnt < half;
      end
    end
    assign CE[i] = ce;
    assign CLKO[i] = ck;
  end
endmodule

// File: tb/tb_pll_clken_gen.sv
// tb_pll_clken_gen: scoreboard bench for pll_clken_gen (lock filter, dividers, config, lock loss)
module tb_pll_clken_gen;
  logic CLKI, RST, LOCK, SYNC, CFG_WE, READY, RSTO;
  logic [2:0] CFG_CH, EN, CE, CLKO;
  logic [15:0] CFG_DIV, CFG_PH;
  int cyc = 0, n_chk = 0, n_err = 0, first;
  int mcnt[3], mdiv[3], mph[3], msd[3], msp[3];
  bit mrun;
  typedef struct {int cyc; logic [2:0] ce; logic [2:0] ck;} ent_t;
  ent_t sb[$];

  pll_clken_gen dut (
    .CLKI(CLKI), .RST(RST), .LOCK(LOCK), .SYNC(SYNC), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
    .CFG_DIV(CFG_DIV), .CFG_PH(CFG_PH), .EN(EN), .CE(CE), .CLKO(CLKO), .READY(READY), .RSTO(RSTO)
  );

  initial begin
    CLKI = 0;
    forever #5 CLKI = ~CLKI;
  end
  always @(posedge CLKI) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      msd[i] = 2;
      msp[i] = 0;
    end
    mrun = 0;
    sb.delete();
  endtask

  task automatic model_start();
    for (int i = 0; i < 3; i++) begin
      mcnt[i] = 0;
      mdiv[i] = msd[i];
      mph[i] = msp[i];
    end
    mrun = 1;
  endtask

  // Drive one cycle of stimulus, push the output expected after the next edge, then compare it.
  task automatic step(input bit we, input int ch, input int dv, input int ph, input bit sy);
    ent_t e;
    int nd;
    CFG_WE = we;
    CFG_CH = 3'(ch);
    CFG_DIV = 16'(dv);
    CFG_PH = 16'(ph);
    SYNC = sy;
    if (mrun) begin
      e.cyc = cyc + 1;
      for (int i = 0; i < 3; i++) begin
        e.ce[i] = EN[i] && mcnt[i] == mph[i];
        e.ck[i] = EN[i] && mcnt[i] < (mdiv[i] + 1) / 2;
      end
      sb.push_back(e);
    end
    if (we && ch < 3) begin
      nd = dv == 0 ? 1 : dv;
      msd[ch] = nd;
      msp[ch] = ph >= nd ? nd - 1 : ph;
    end
    if (mrun)
      for (int i = 0; i < 3; i++)
        if (sy || mcnt[i] == mdiv[i] - 1) begin
          mcnt[i] = 0;
          mdiv[i] = msd[i];
          mph[i] = msp[i];
        end else mcnt[i]++;
    @(negedge CLKI);
    CFG_WE = 0;
    SYNC = 0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("ce", int'(CE), int'(e.ce));
      chk("clko", int'(CLKO), int'(e.ck));
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic wait_ready(input string tag);
    for (int n = 0; n < 400 && !READY; n++) step(0, 0, 0, 0, 0);
    chk(tag, cyc - first, 258);
  endtask

  initial begin
    RST = 1; LOCK = 0; SYNC = 0; CFG_WE = 1; CFG_CH = 0; CFG_DIV = 7; CFG_PH = 0; EN = 3'b111;
    repeat (3) @(negedge CLKI);
    chk("rst_ready", READY, 0);
    chk("rst_rsto", RSTO, 1);
    chk("rst_ce", CE, 0);
    chk("rst_clko", CLKO, 0);
    RST = 0;
    CFG_WE = 0;
    model_reset();
    step(1, 0, 4, 0, 0);
    step(1, 1, 8, 0, 0);
    step(1, 2, 16, 0, 0);
    step(1, 7, 3, 1, 0);
    chk("idle_ready", READY, 0);
    LOCK = 1;
    first = cyc + 1;
    wait_ready("lock_latency");
    chk("rsto_before", RSTO, 1);
    model_start();
    step(0, 0, 0, 0, 0);
    chk("rsto_after", RSTO, 0);
    run(39);
    for (int k = 0; k < 20 && mcnt[0] != 1; k++) step(0, 0, 0, 0, 0);
    step(1, 0, 5, 0, 0);
    run(12);
    for (int k = 0; k < 20 && mcnt[0] != mdiv[0] - 1; k++) step(0, 0, 0, 0, 0);
    step(1, 0, 6, 0, 0);
    run(14);
    step(1, 2, 6, 20, 0);
    run(20);
    EN = 3'b101;
    run(10);
    EN = 3'b111;
    run(10);
    step(1, 1, 0, 9, 0);
    step(1, 7, 3, 1, 0);
    run(20);
    step(0, 0, 0, 0, 1);
    run(20);
    LOCK = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ready_hold", READY, 1);
    step(0, 0, 0, 0, 0);
    chk("ready_drop", READY, 0);
    mrun = 0;
    step(0, 0, 0, 0, 0);
    chk("drop_ce", CE, 0);
    chk("drop_clko", CLKO, 0);
    chk("drop_rsto", RSTO, 1);
    LOCK = 1;
    first = cyc + 1;
    wait_ready("relock_latency");
    model_start();
    run(40);
    RST = 1; LOCK = 1; SYNC = 1; CFG_WE = 1; CFG_CH = 0; CFG_DIV = 7; CFG_PH = 3;
    repeat (3) @(negedge CLKI);
    chk("rst2_ready", READY, 0);
    chk("rst2_rsto", RSTO, 1);
    RST = 0;
    CFG_WE = 0;
    SYNC = 0;
    model_reset();
    first = cyc + 1;
    run(103);
    LOCK = 0;
    step(0, 0, 0, 0, 0);
    LOCK = 1;
    first = cyc + 1;
    wait_ready("glitch_latency");
    model_start();
    run(12);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pll_clken_gen.md
PLL_CLKEN_GEN -- requirements
Module: pll_clken_gen

Interface
REQ-001 SHALL have parameter NCH, default 3, number of output channels (1..8).
REQ-002 SHALL have parameter CW, default 16, divider/phase counter width.
REQ-003 SHALL have parameter LOCK_FILT, default 256, consecutive LOCK-high cycles required before READY.
REQ-004 SHALL have parameter DEF_DIV, default 2, reset divide ratio of every channel.
REQ-005 SHALL have port CLKI  input  1  single clock (PLL CLKOP domain); all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port LOCK  input  1  PLL lock, asynchronous to CLKI.
REQ-008 SHALL have port SYNC  input  1  one-cycle pulse restarting all channel counters together.
REQ-009 SHALL have port CFG_WE  input  1  config write strobe.
REQ-010 SHALL have port CFG_CH  input  3  channel index for write; index >= NCH ignored.
REQ-011 SHALL have port CFG_DIV  input  CW  divide ratio; 0 treated as 1.
REQ-012 SHALL have port CFG_PH  input  CW  strobe phase in cycles; values >= DIV clamped to DIV-1.
REQ-013 SHALL have port EN  input  NCH  per-channel output enable.
REQ-014 SHALL have port CE  output  NCH  one-cycle clock-enable strobes, one per period.
REQ-015 SHALL have port CLKO  output  NCH  registered divided square wave per channel.
REQ-016 SHALL have port READY  output  1  lock-filtered PLL-good flag.
REQ-017 SHALL have port RSTO  output  1  registered downstream reset, equal to NOT READY.

Function
REQ-018 SHALL synchronise LOCK through a 2-flop synchroniser before any use.
REQ-019 SHALL implement lock FSM IDLE -> FILT when synced LOCK=1; FILT -> RUN after LOCK_FILT consecutive synced-high cycles; FILT -> IDLE on any synced-low cycle (counter cleared); RUN -> IDLE on any synced-low cycle.
REQ-020 SHALL assert READY exactly in RUN; RSTO = registered NOT READY, so RSTO falls one cycle after READY rises and rises one cycle after READY falls.
REQ-021 SHALL hold per-channel active DIV, active PH, shadow DIV, shadow PH, counter cnt (CW bits).
REQ-022 SHALL on CFG_WE write CFG_DIV (0 -> 1) and clamped CFG_PH to the shadow registers of CFG_CH.
REQ-023 SHALL copy shadow to active only at the channel wrap (cnt == DIV-1) or on resync; a write in the same cycle as wrap/resync SHALL be copied (write-through).
REQ-024 SHALL increment cnt each cycle in RUN, wrapping from active DIV-1 to 0; cnt held at 0 outside RUN.
REQ-025 SHALL resync (all cnt := 0, shadow -> active) on SYNC in RUN and on the IDLE/FILT -> RUN transition; SYNC outside RUN ignored.
REQ-026 SHALL assert CE[i] registered, one cycle after cnt == active PH, only when READY and EN[i]; DIV=1 gives CE high every cycle.
REQ-027 SHALL drive CLKO[i] registered high while cnt < (DIV+1)/2 (integer), else low; forced 0 when not READY or EN[i]=0; DIV=1 gives constant high.
REQ-028 SHALL, with EN[i] deasserted, keep cnt[i] running so re-enable stays phase-aligned with other channels.
REQ-029 SHALL, on LOCK loss mid-period, drop CE/CLKO to 0 the cycle after READY falls and restart from cnt=0 on next RUN entry.

Reset
REQ-030 SHALL on RST: FSM IDLE, filter counter 0, READY=0, RSTO=1, CE=0, CLKO=0, all cnt=0, active/shadow DIV=DEF_DIV, PH=0, synchroniser flops 0.
REQ-031 SHALL give RST priority over CFG_WE, SYNC and LOCK in the same cycle.

Verification
REQ-032 LOCK high steady after RST release, LOCK_FILT=256 -> READY rises 2+256 cycles after first LOCK-high sample, RSTO falls one cycle later.
REQ-033 LOCK glitch low for 1 cycle at filter count 100 -> filter restarts, READY delayed by the full 256 cycles from the glitch.
REQ-034 Channels DIV=4/8/16, PH=0 -> CE periods 4/8/16 cycles, all first strobes on the same cycle; CLKO duty 2/4, 4/8, 8/16.
REQ-035 Write DIV=5 to channel 0 mid-period of DIV=4 -> current period completes at 4, next period is 5; write coinciding with wrap -> next period is 5.
REQ-036 CFG_DIV=0, CFG_PH=9 to channel 1 -> behaves as DIV=1: CE and CLKO continuously high; CFG_CH=7 with NCH=3 -> no state change.
REQ-037 LOCK drop during RUN, then restore -> CE/CLKO 0 and RSTO=1 within 3 cycles of drop; counters restart aligned after refilter.
